// File: rtl/uart_rx_ctrl_if.sv
// Bundle between the UART receive controller, the UART receiver and the host-side consumer.
// The master modport is the controller's view; slave is the surrounding logic.
interface uart_rx_ctrl_if #(
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          enable;
  logic          rx_en;
  logic          rx_done;
  logic [7:0]    rx_data;
  logic [7:0]    m_data;
  logic          m_valid;
  logic          m_ready;
  logic [CW-1:0] count;
  logic          overflow;
  logic          clr_ovf;
  logic          pkt_end;

  modport master (
    input  enable, rx_done, rx_data, m_ready, clr_ovf,
    output rx_en, m_data, m_valid, count, overflow, pkt_end
  );

  modport slave (
    output enable, rx_done, rx_data, m_ready, clr_ovf,
    input  rx_en, m_data, m_valid, count, overflow, pkt_end
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: edge-detects receiver strobes into a show-ahead byte FIFO,
// gates the receiver read-enable, flags overflow and pulses pkt_end after a line-idle gap.
module uart_rx_ctrl #(
  parameter int SEQ        = 100000000,
  parameter int BAUD_RATE  = 9600,
  parameter int DEPTH      = 16,
  parameter int IDLE_CHARS = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  uart_rx_ctrl_if.master bus
);
  localparam int T_CHAR    = 10 * (SEQ / BAUD_RATE);
  localparam int IDLE_CLKS = IDLE_CHARS * T_CHAR;
  localparam int TW        = (IDLE_CLKS > 1) ? $clog2(IDLE_CLKS) : 1;
  localparam int AW        = $clog2(DEPTH);
  localparam int CW        = AW + 1;

  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [TW-1:0] IDLE_LAST = TW'(IDLE_CLKS - 1);

  // RUN is the only encoding with bit 0 set, so that bit drives rx_en directly
  typedef enum logic [1:0] {
    OFF  = 2'b00,
    RUN  = 2'b01,
    FULL = 2'b10
  } state_t;

  logic [7:0]    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [CW-1:0] count_r;
  logic [7:0]    m_data_r;
  logic          m_valid_r;
  logic          overflow_r;
  logic          pkt_end_r;
  logic          rx_done_q_r;
  logic          done_low_r;
  logic [TW-1:0] idle_cnt_r;
  logic          armed_r;
  state_t        state_r;

  logic          push_s, pop_s, acc_s, rej_s;
  logic [CW-1:0] count_nxt_s;
  logic [AW-1:0] wr_ptr_nxt_s, rd_ptr_nxt_s;
  logic [7:0]    head_nxt_s;
  state_t        state_nxt_s;

  // done_low_r blocks a strobe that was already high across reset release
  assign push_s = bus.rx_done & ~rx_done_q_r & done_low_r;
  assign pop_s  = m_valid_r & bus.m_ready;
  assign acc_s  = push_s & ((count_r != DEPTH_C) | pop_s);
  assign rej_s  = push_s & ~acc_s;

  // Next occupancy, pointers, head byte and FSM state
  always_comb begin
    count_nxt_s  = count_r;
    wr_ptr_nxt_s = wr_ptr_r;
    rd_ptr_nxt_s = rd_ptr_r;
    head_nxt_s   = 8'h00;
    state_nxt_s  = OFF;

    case ({acc_s, pop_s})
      2'b10:   count_nxt_s = count_r + CW'(1);
      2'b01:   count_nxt_s = count_r - CW'(1);
      default: count_nxt_s = count_r;
    endcase

    if (acc_s) wr_ptr_nxt_s = wr_ptr_r + AW'(1);
    else       wr_ptr_nxt_s = wr_ptr_r;
    if (pop_s) rd_ptr_nxt_s = rd_ptr_r + AW'(1);
    else       rd_ptr_nxt_s = rd_ptr_r;

    // the slot being written this cycle is not yet readable from mem_r
    if (count_nxt_s == CW'(0))                     head_nxt_s = 8'h00;
    else if (acc_s && (wr_ptr_r == rd_ptr_nxt_s))  head_nxt_s = bus.rx_data;
    else                                           head_nxt_s = mem_r[rd_ptr_nxt_s];

    if (!bus.enable)                  state_nxt_s = OFF;
    else if (count_nxt_s == DEPTH_C)  state_nxt_s = FULL;
    else                              state_nxt_s = RUN;
  end

  // Byte storage, deliberately not reset
  always_ff @(posedge clk) begin
    if (acc_s) mem_r[wr_ptr_r] <= bus.rx_data;
  end

  // FIFO bookkeeping, strobe edge detector and overflow flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      count_r     <= '0;
      m_data_r    <= 8'h00;
      m_valid_r   <= 1'b0;
      overflow_r  <= 1'b0;
      rx_done_q_r <= 1'b0;
      done_low_r  <= 1'b0;
    end else begin
      wr_ptr_r    <= wr_ptr_nxt_s;
      rd_ptr_r    <= rd_ptr_nxt_s;
      count_r     <= count_nxt_s;
      m_data_r    <= head_nxt_s;
      m_valid_r   <= (count_nxt_s != CW'(0));
      rx_done_q_r <= bus.rx_done;
      if (!bus.rx_done) done_low_r <= 1'b1;
      else              done_low_r <= done_low_r;
      if (rej_s)             overflow_r <= 1'b1;
      else if (bus.clr_ovf)  overflow_r <= 1'b0;
      else                   overflow_r <= overflow_r;
    end
  end

  // Receiver gating state machine
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= OFF;
    else        state_r <= state_nxt_s;
  end

  // Line-idle timer: any push (accepted or not) restarts the gap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt_r <= '0;
      armed_r    <= 1'b0;
      pkt_end_r  <= 1'b0;
    end else if (push_s) begin
      idle_cnt_r <= '0;
      armed_r    <= 1'b1;
      pkt_end_r  <= 1'b0;
    end else if (armed_r && (idle_cnt_r == IDLE_LAST)) begin
      idle_cnt_r <= '0;
      armed_r    <= 1'b0;
      pkt_end_r  <= 1'b1;
    end else if (armed_r) begin
      idle_cnt_r <= idle_cnt_r + TW'(1);
      armed_r    <= 1'b1;
      pkt_end_r  <= 1'b0;
    end else begin
      idle_cnt_r <= idle_cnt_r;
      armed_r    <= 1'b0;
      pkt_end_r  <= 1'b0;
    end
  end

  assign bus.rx_en    = state_r[0];
  assign bus.m_data   = m_data_r;
  assign bus.m_valid  = m_valid_r;
  assign bus.count    = count_r;
  assign bus.overflow = overflow_r;
  assign bus.pkt_end  = pkt_end_r;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed scenarios plus a randomized run,
// all compared against a queue-based reference model with T_CHAR=100, IDLE_CHARS=2.
module tb_uart_rx_ctrl;
  localparam int SEQ        = 1000;
  localparam int BAUD_RATE  = 100;
  localparam int DEPTH      = 16;
  localparam int IDLE_CHARS = 2;
  localparam int IDLE_CLKS  = 200;
  localparam int CW         = $clog2(DEPTH) + 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  uart_rx_ctrl_if #(.DEPTH(DEPTH)) bus ();

  uart_rx_ctrl #(
    .SEQ(SEQ), .BAUD_RATE(BAUD_RATE), .DEPTH(DEPTH), .IDLE_CHARS(IDLE_CHARS)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.master)
  );

  always #5 clk = ~clk;

  // reference model state
  logic [7:0] byte_q [$];
  bit         m_ovf;
  bit         prev_done;
  bit         armed;
  bit         exp_pkt;
  int         cyc;
  int         last_push;
  int         pass_cnt  = 0;
  int         total_cnt = 0;

  task automatic reset_model();
    byte_q.delete();
    m_ovf     = 1'b0;
    prev_done = 1'b1;
    armed     = 1'b0;
    exp_pkt   = 1'b0;
  endtask

  // one clock edge; model applies the same edge from the driven inputs
  task automatic step();
    bit         push, pop, acc;
    logic [7:0] d;
    d    = bus.rx_data;
    push = bus.rx_done && !prev_done;
    pop  = bus.m_ready && (byte_q.size() != 0);
    acc  = push && ((byte_q.size() < DEPTH) || pop);
    @(posedge clk);
    cyc++;
    if (pop) void'(byte_q.pop_front());
    if (acc) byte_q.push_back(d);
    if (push && !acc)  m_ovf = 1'b1;
    else if (bus.clr_ovf) m_ovf = 1'b0;
    prev_done = bus.rx_done;
    exp_pkt   = !push && armed && (cyc - last_push == IDLE_CLKS);
    if (push) begin
      last_push = cyc;
      armed     = 1'b1;
    end else if (exp_pkt) begin
      armed = 1'b0;
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.enable = 1'b0; bus.rx_done = 1'b0; bus.rx_data = 8'h00;
    bus.m_ready = 1'b0; bus.clr_ovf = 1'b0;
    reset_model();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int width);
    bus.rx_data = b;
    bus.rx_done = 1'b1;
    repeat (width) step();
    bus.rx_done = 1'b0;
    step();
  endtask

  task automatic test_reset();
    int highs;
    bus.enable = 1'b1; bus.rx_done = 1'b0; bus.rx_data = 8'h00;
    bus.m_ready = 1'b0; bus.clr_ovf = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    total_cnt++; if (bus.rx_en !== 1'b0) $display("FAIL reset_rx_en got=%b exp=0", bus.rx_en); else pass_cnt++;
    total_cnt++; if (bus.m_valid !== 1'b0) $display("FAIL reset_m_valid got=%b exp=0", bus.m_valid); else pass_cnt++;
    total_cnt++; if (bus.m_data !== 8'h00) $display("FAIL reset_m_data got=%h exp=00", bus.m_data); else pass_cnt++;
    total_cnt++; if (bus.count !== CW'(0)) $display("FAIL reset_count got=%0d exp=0", bus.count); else pass_cnt++;
    total_cnt++; if (bus.overflow !== 1'b0) $display("FAIL reset_overflow got=%b exp=0", bus.overflow); else pass_cnt++;
    total_cnt++; if (bus.pkt_end !== 1'b0) $display("FAIL reset_pkt_end got=%b exp=0", bus.pkt_end); else pass_cnt++;
    bus.enable = 1'b0;
    reset_model();
    @(negedge clk);
    rst_n = 1'b1;
    highs = 0;
    for (int k = 0; k < 300; k++) begin
      step();
      if (bus.pkt_end === 1'b1 || bus.rx_en !== 1'b0) highs++;
    end
    total_cnt++; if (highs != 0) $display("FAIL reset_no_pkt_end got=%0d exp=0", highs); else pass_cnt++;
    bus.enable = 1'b1;
    step();
    total_cnt++; if (bus.rx_en !== 1'b1) $display("FAIL reset_enable_rx_en got=%b exp=1", bus.rx_en); else pass_cnt++;
  endtask

  task automatic test_basic();
    logic [7:0] bb [3];
    bb[0] = 8'hA5; bb[1] = 8'h3C; bb[2] = 8'hFF;
    do_reset();
    bus.enable = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      send_byte(bb[i], 2);
      step();
    end
    total_cnt++; if (bus.count !== CW'(3)) $display("FAIL basic_count got=%0d exp=3", bus.count); else pass_cnt++;
    total_cnt++; if (bus.m_valid !== 1'b1) $display("FAIL basic_valid got=%b exp=1", bus.m_valid); else pass_cnt++;
    total_cnt++; if (bus.m_data !== 8'hA5) $display("FAIL basic_head got=%h exp=a5", bus.m_data); else pass_cnt++;
    bus.m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total_cnt++; if (bus.m_data !== bb[i]) $display("FAIL basic_drain%0d got=%h exp=%h", i, bus.m_data, bb[i]); else pass_cnt++;
      step();
    end
    total_cnt++; if (bus.m_valid !== 1'b0) $display("FAIL basic_empty_valid got=%b exp=0", bus.m_valid); else pass_cnt++;
    total_cnt++; if (bus.m_data !== 8'h00) $display("FAIL basic_empty_data got=%h exp=00", bus.m_data); else pass_cnt++;
    bus.m_ready = 1'b0;
  endtask

  task automatic fill16();
    for (int i = 0; i < DEPTH; i++) begin
      bus.rx_data = 8'($urandom);
      bus.rx_done = 1'b1;
      step();
      if (i == DEPTH - 2) begin
        total_cnt++; if (bus.rx_en !== 1'b1) $display("FAIL fill_rx_en_15 got=%b exp=1", bus.rx_en); else pass_cnt++;
      end else if (i == DEPTH - 1) begin
        total_cnt++; if (bus.rx_en !== 1'b0) $display("FAIL fill_rx_en_16 got=%b exp=0", bus.rx_en); else pass_cnt++;
      end else begin
        bus.rx_done = 1'b1;
      end
      bus.rx_done = 1'b0;
      step();
    end
  endtask

  task automatic test_overflow();
    do_reset();
    bus.enable = 1'b1;
    step();
    fill16();
    total_cnt++; if (bus.count !== CW'(16)) $display("FAIL ovf_full_count got=%0d exp=16", bus.count); else pass_cnt++;
    send_byte(8'h5A, 1);
    total_cnt++; if (bus.overflow !== 1'b1) $display("FAIL ovf_flag got=%b exp=1", bus.overflow); else pass_cnt++;
    total_cnt++; if (bus.count !== CW'(16)) $display("FAIL ovf_count got=%0d exp=16", bus.count); else pass_cnt++;
    bus.clr_ovf = 1'b1;
    step();
    bus.clr_ovf = 1'b0;
    total_cnt++; if (bus.overflow !== 1'b0) $display("FAIL ovf_clear got=%b exp=0", bus.overflow); else pass_cnt++;
    bus.m_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      total_cnt++;
      if (bus.m_data !== byte_q[0]) $display("FAIL ovf_drain%0d got=%h exp=%h", i, bus.m_data, byte_q[0]); else pass_cnt++;
      step();
    end
    total_cnt++; if (bus.m_valid !== 1'b0) $display("FAIL ovf_drained got=%b exp=0", bus.m_valid); else pass_cnt++;
    bus.m_ready = 1'b0;
  endtask

  task automatic test_full_push_pop();
    logic [7:0] last;
    last = 8'h00;
    do_reset();
    bus.enable = 1'b1;
    step();
    fill16();
    bus.rx_data = 8'hC3; bus.rx_done = 1'b1; bus.m_ready = 1'b1;
    step();
    bus.rx_done = 1'b0; bus.m_ready = 1'b0;
    total_cnt++; if (bus.count !== CW'(16)) $display("FAIL fpp_count got=%0d exp=16", bus.count); else pass_cnt++;
    total_cnt++; if (bus.overflow !== 1'b0) $display("FAIL fpp_overflow got=%b exp=0", bus.overflow); else pass_cnt++;
    bus.m_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      total_cnt++;
      if (bus.m_data !== byte_q[0]) $display("FAIL fpp_drain%0d got=%h exp=%h", i, bus.m_data, byte_q[0]); else pass_cnt++;
      last = bus.m_data;
      step();
    end
    total_cnt++; if (last !== 8'hC3) $display("FAIL fpp_last got=%h exp=c3", last); else pass_cnt++;
    bus.m_ready = 1'b0;
  endtask

  task automatic test_pkt_end();
    int p0, first, highs;
    do_reset();
    bus.enable = 1'b1;
    step();
    bus.rx_data = 8'($urandom); bus.rx_done = 1'b1;
    step();
    p0 = cyc;
    bus.rx_done = 1'b0;
    first = -1; highs = 0;
    for (int k = 0; k < 400; k++) begin
      step();
      if (bus.pkt_end === 1'b1) begin
        highs++;
        if (first < 0) first = cyc;
      end
    end
    total_cnt++; if (first - p0 != IDLE_CLKS) $display("FAIL pkt_delay got=%0d exp=%0d", first - p0, IDLE_CLKS); else pass_cnt++;
    total_cnt++; if (highs != 1) $display("FAIL pkt_single got=%0d exp=1", highs); else pass_cnt++;
    // retrigger with the receiver disabled: the gap restarts from the second byte
    bus.enable = 1'b0;
    bus.rx_data = 8'($urandom); bus.rx_done = 1'b1;
    step();
    p0 = cyc;
    bus.rx_done = 1'b0;
    first = -1; highs = 0;
    for (int k = 0; k < 149; k++) begin
      step();
      if (bus.pkt_end === 1'b1) highs++;
    end
    bus.rx_data = 8'($urandom); bus.rx_done = 1'b1;
    step();
    total_cnt++; if (cyc - p0 != 150) $display("FAIL pkt_second_at got=%0d exp=150", cyc - p0); else pass_cnt++;
    p0 = cyc;
    bus.rx_done = 1'b0;
    for (int k = 0; k < 400; k++) begin
      step();
      if (bus.pkt_end === 1'b1) begin
        highs++;
        if (first < 0) first = cyc;
      end
    end
    total_cnt++; if (first - p0 != IDLE_CLKS) $display("FAIL pkt_retrig_delay got=%0d exp=%0d", first - p0, IDLE_CLKS); else pass_cnt++;
    total_cnt++; if (highs != 1) $display("FAIL pkt_retrig_single got=%0d exp=1", highs); else pass_cnt++;
  endtask

  task automatic test_enable_off();
    do_reset();
    bus.enable = 1'b1;
    step(); step();
    bus.enable = 1'b0;
    step();
    send_byte(8'h96, 1);
    total_cnt++; if (bus.rx_en !== 1'b0) $display("FAIL enoff_rx_en got=%b exp=0", bus.rx_en); else pass_cnt++;
    total_cnt++; if (bus.count !== CW'(1)) $display("FAIL enoff_count got=%0d exp=1", bus.count); else pass_cnt++;
    total_cnt++; if (bus.m_data !== 8'h96) $display("FAIL enoff_data got=%h exp=96", bus.m_data); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int bad_cnt, bad_pkt;
    do_reset();
    bus.enable = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      bus.rx_data = 8'(8'h10 + i); bus.rx_done = 1'b1;
      step();
      if (i < 4) begin
        bus.rx_done = 1'b0;
        step();
      end
    end
    total_cnt++; if (bus.count !== CW'(5)) $display("FAIL rmid_pre_count got=%0d exp=5", bus.count); else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({bus.rx_en, bus.m_valid, bus.m_data, bus.count, bus.overflow, bus.pkt_end} !== '0)
      $display("FAIL rmid_outputs got=%b%b_%h_%0d_%b%b exp=all zero", bus.rx_en, bus.m_valid, bus.m_data, bus.count, bus.overflow, bus.pkt_end);
    else pass_cnt++;
    reset_model();
    @(negedge clk);
    rst_n = 1'b1;
    bad_cnt = 0; bad_pkt = 0;
    for (int k = 0; k < 250; k++) begin
      step();
      if (bus.count !== CW'(0)) bad_cnt++;
      if (bus.pkt_end !== 1'b0) bad_pkt++;
    end
    total_cnt++; if (bad_cnt != 0) $display("FAIL rmid_held_no_push got=%0d exp=0", bad_cnt); else pass_cnt++;
    total_cnt++; if (bad_pkt != 0) $display("FAIL rmid_no_pkt_end got=%0d exp=0", bad_pkt); else pass_cnt++;
    bus.rx_done = 1'b0;
    step();
    send_byte(8'h77, 1);
    total_cnt++; if (bus.count !== CW'(1)) $display("FAIL rmid_toggle_count got=%0d exp=1", bus.count); else pass_cnt++;
    total_cnt++; if (bus.m_data !== 8'h77) $display("FAIL rmid_toggle_data got=%h exp=77", bus.m_data); else pass_cnt++;
  endtask

  task automatic test_random();
    int sent, hold, guard;
    logic [7:0] exp_data;
    do_reset();
    bus.enable = 1'b1;
    step();
    sent = 0; hold = 0; guard = 0;
    while (guard < 3000 && (sent < 40 || hold > 0 || byte_q.size() != 0)) begin
      guard++;
      if (hold > 0) begin
        hold--;
        if (hold == 0) bus.rx_done = 1'b0;
      end else if (sent < 40 && $urandom_range(0, 2) == 0) begin
        bus.rx_done = 1'b1;
        bus.rx_data = 8'($urandom);
        hold = $urandom_range(1, 2);
        sent++;
      end
      bus.m_ready = (sent < 40) ? ($urandom_range(0, 9) < 4) : 1'b1;
      bus.clr_ovf = ($urandom_range(0, 19) == 0);
      step();
      exp_data = (byte_q.size() != 0) ? byte_q[0] : 8'h00;
      total_cnt++; if (bus.m_data !== exp_data) $display("FAIL rnd_data c%0d got=%h exp=%h", cyc, bus.m_data, exp_data); else pass_cnt++;
      total_cnt++; if (bus.m_valid !== (byte_q.size() != 0)) $display("FAIL rnd_valid c%0d got=%b exp=%b", cyc, bus.m_valid, byte_q.size() != 0); else pass_cnt++;
      total_cnt++; if (bus.count !== CW'(byte_q.size())) $display("FAIL rnd_count c%0d got=%0d exp=%0d", cyc, bus.count, byte_q.size()); else pass_cnt++;
      total_cnt++; if (bus.overflow !== m_ovf) $display("FAIL rnd_ovf c%0d got=%b exp=%b", cyc, bus.overflow, m_ovf); else pass_cnt++;
      total_cnt++; if (bus.rx_en !== (byte_q.size() < DEPTH)) $display("FAIL rnd_rx_en c%0d got=%b exp=%b", cyc, bus.rx_en, byte_q.size() < DEPTH); else pass_cnt++;
      total_cnt++; if (bus.pkt_end !== exp_pkt) $display("FAIL rnd_pkt c%0d got=%b exp=%b", cyc, bus.pkt_end, exp_pkt); else pass_cnt++;
    end
    total_cnt++; if (sent != 40 || byte_q.size() != 0) $display("FAIL rnd_budget sent=%0d exp=40 left=%0d", sent, byte_q.size()); else pass_cnt++;
    bus.rx_done = 1'b0; bus.m_ready = 1'b0; bus.clr_ovf = 1'b0;
  endtask

  initial begin
    cyc = 0; last_push = 0;
    reset_model();
    test_reset();
    test_basic();
    test_overflow();
    test_full_push_pop();
    test_pkt_end();
    test_enable_off();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached passed=%0d total=%0d", pass_cnt, total_cnt);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Receive-side controller that sequences the UART receiver and buffers its output. It drives the receiver's read-enable, detects each completed byte, and stores the bytes in a show-ahead FIFO drained through a valid/ready port. It flags overflow and signals end-of-packet after a configurable line-idle gap. It sits between the UART receiver and the host/bus logic.

## Interface
- SEQ, 100000000, system clock frequency in Hz
- BAUD_RATE, 9600, line baud rate; one character time is T_CHAR = 10*(SEQ/BAUD_RATE) clocks
- DEPTH, 16, FIFO depth in bytes; power of two, ≥2
- IDLE_CHARS, 4, idle gap in character times that ends a packet; ≥1
- clk  input  1  system clock; all logic on rising edge
- rst_n  input  1  asynchronous, active-low reset
- enable  input  1  1 = accept new bytes from the line
- rx_en  output  1  read-enable to receiver
- rx_done  input  1  receiver byte-complete strobe; may stay high more than one cycle
- rx_data  input  8  receiver byte, valid while rx_done is high
- m_data  output  8  FIFO head byte; 8'h00 while m_valid=0
- m_valid  output  1  FIFO not empty
- m_ready  input  1  consumer accepts head byte
- count  output  $clog2(DEPTH)+1  bytes held, 0..DEPTH
- overflow  output  1  sticky: a byte was dropped
- clr_ovf  input  1  clears overflow
- pkt_end  output  1  one-cycle pulse: line idle for IDLE_CHARS after the last byte

## Operation
- Reset values: rx_en=0, m_valid=0, m_data=8'h00, count=0, overflow=0, pkt_end=0, state=OFF, pointers=0, idle counter=0, armed flag=0, rx_done_q=0. Storage contents are not reset.
- Byte event: push = rx_done & ~rx_done_q. rx_done_q is rx_done registered each cycle. A multi-cycle rx_done produces exactly one push.
- A push is accepted regardless of state or enable, so a byte already in flight when enable falls is still stored.
- Pop = m_valid & m_ready.
- Push is accepted iff count<DEPTH or pop in the same cycle.
  - Rejected push: byte discarded, overflow←1.
  - clr_ovf clears overflow. If clr_ovf and a rejected push occur in the same cycle, overflow stays 1.
- Simultaneous accepted push and pop: count unchanged, both pointers advance. This includes the count=DEPTH case.
- Pointers are $clog2(DEPTH) bits and wrap DEPTH-1→0.
- State machine: states OFF, RUN, FULL. Next state is computed from enable and next-count:
  - enable=0 → OFF
  - enable=1 and next-count<DEPTH → RUN
  - enable=1 and next-count=DEPTH → FULL
- rx_en = (state==RUN), registered.
- Idle timer, in clocks:
  - An accepted or rejected push reloads the counter to 0 and sets armed=1.
  - While armed and no push, the counter increments.
  - On reaching IDLE_CHARS*T_CHAR-1: pkt_end=1 for one cycle, armed←0, counter holds at 0.
  - Counter width is $clog2(IDLE_CHARS*T_CHAR). No wrap occurs while armed.
- pkt_end fires independently of enable. It never fires before the first byte after reset.

## Timing
- rx_done rising at edge N (first cycle sampled high): byte written and count incremented at edge N.
  - If the FIFO was empty, m_valid=1 and m_data=byte after edge N.
- Pop at edge N: head and count update after edge N; the next byte is visible in the same cycle.
- rx_en follows state with one-cycle latency. For example, the push that fills the FIFO at edge N gives rx_en=0 after edge N.
- The receiver samples rx_en only when idle, so rx_en falling mid-frame does not abort the frame.
- pkt_end asserts exactly IDLE_CHARS*T_CHAR cycles after the last push edge.
- Reset mid-operation clears all state immediately, including a pending pkt_end and the FIFO. A concurrent rx_done high produces no push until it falls and rises again after reset release.

## Test plan
- Reset, enable=1, three rx_done pulses (2 cycles wide) with 8'hA5, 8'h3C, 8'hFF, m_ready=0 → count=3, m_valid=1, m_data=8'hA5, exactly three pushes. Then m_ready=1 → A5, 3C, FF on consecutive cycles, then m_valid=0 and m_data=8'h00.
- Fill DEPTH=16 bytes with m_ready=0 → rx_en=0 one cycle after the 16th push, state FULL. A 17th rx_done → byte dropped, overflow=1, count=16. clr_ovf pulse → overflow=0.
- count=16: push and pop in the same cycle → count stays 16, overflow=0, the new byte is read last.
- Small SEQ/BAUD_RATE (e.g. T_CHAR=100, IDLE_CHARS=2), one byte → pkt_end single pulse exactly 200 cycles after the push. A second byte at cycle 150 → pulse 200 cycles after that byte instead. No pulse after reset without bytes.
- Deassert enable one cycle before rx_done → rx_en=0, byte still stored.
- Assert rst_n=0 with count=5 and rx_done held high → all outputs at reset values. After release, no push until rx_done toggles.
- 40 random pushes and pops with pointer wrap → output order matches a scoreboard.
